// File: rtl/palette_pkg.sv
// ---------------------------------------------------------------------------
// palette_pkg
// Shared definitions for the palette write path: address/data widths,
// channel select codes, the loader state encoding and the packed palette
// address used between the loader and its address sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package palette_pkg;

    localparam int LAYER_W         = 5;
    localparam int COLOR_W         = 5;
    localparam int PAL_DATA_W      = 16;
    // Color slot 0 of every layer is transparent and never written.
    localparam int TRANSPARENT_IDX = 0;

    localparam logic [1:0] CH_R = 2'b00;
    localparam logic [1:0] CH_G = 2'b01;
    localparam logic [1:0] CH_B = 2'b10;
    localparam logic [1:0] CH_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FINISH = 2'd3
    } loader_state_t;

    typedef struct packed {
        logic [LAYER_W-1:0] layer;
        logic [COLOR_W-1:0] color;
        logic [1:0]         rgb;
    } pal_addr_t;

    // Channel order within one color: R -> G -> B -> R.
    function automatic logic [1:0] next_channel(input logic [1:0] ch);
        case (ch)
            CH_R:       next_channel = CH_G;
            CH_G:       next_channel = CH_B;
            CH_B, CH_X: next_channel = CH_R;
            default:    next_channel = CH_R;
        endcase
    endfunction

endpackage

// File: rtl/palette_addr_seq.sv
// ---------------------------------------------------------------------------
// palette_addr_seq
// Channel / color / layer counter for a palette upload. Walks R, G, B of a
// color, then moves to the next color slot. Slot 0 is skipped: color 31
// wraps to color 1 of the next layer, and layer 31 wraps to layer 0.
//
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   load         capture load_layer / load_color / load_count, channel <- R
//   advance      step to the next channel (and color after B)
//   load_layer   starting layer
//   load_color   starting color slot (0 is promoted to 1)
//   load_count   number of colors to walk
//   addr         current {layer, color, channel}
//   last         current address is the B channel of the final color
// ---------------------------------------------------------------------------
module palette_addr_seq
    import palette_pkg::*;
#(
    parameter int COUNT_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [LAYER_W-1:0] load_layer,
    input  logic [COLOR_W-1:0] load_color,
    input  logic [COUNT_W-1:0] load_count,
    output pal_addr_t          addr,
    output logic               last
);

    logic [COUNT_W-1:0] remaining;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr.layer <= load_layer;
            addr.color <= (load_color == COLOR_W'(TRANSPARENT_IDX)) ? COLOR_W'(1) : load_color;
            addr.rgb   <= CH_R;
            remaining  <= load_count;
        end else if (advance) begin
            addr.rgb <= next_channel(addr.rgb);
            if (addr.rgb == CH_B) begin
                remaining <= remaining - COUNT_W'(1);
                if (addr.color == '1) begin
                    addr.color <= COLOR_W'(1);
                    addr.layer <= addr.layer + LAYER_W'(1);
                end else begin
                    addr.color <= addr.color + COLOR_W'(1);
                end
            end
        end
    end

    assign last = (addr.rgb == CH_B) && (remaining == COUNT_W'(1));

endmodule

// File: rtl/palette_loader.sv
// ---------------------------------------------------------------------------
// palette_loader
// Write engine for the palette memory. A load command (layer, start color,
// color count) is followed by a stream of 16-bit channel words, R, G, B per
// color; each accepted word becomes one registered palette write.
//
// Build option: define PALETTE_LOADER_VERIFY_EN to read back every write
// after RD_LAT + 1 cycles and flag mismatches on verify_err.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   cmd_valid / cmd_ready     load command handshake (ready only in IDLE)
//   cmd_layer, cmd_color      starting address (color 0 treated as 1)
//   cmd_count                 number of colors (3 words each); 0 = no writes
//   s_valid / s_ready, s_data channel word stream
//   pal_write_en              palette write strobe
//   pal_layer, pal_color      palette address
//   pal_rgb                   channel select (00 R, 01 G, 10 B)
//   pal_write_data            palette write data
//   pal_read_data             palette read data (verify builds only)
//   busy                      command in progress (LOAD / VERIFY)
//   done                      one-cycle completion pulse
//   verify_err                sticky readback mismatch, cleared on accept
// ---------------------------------------------------------------------------
module palette_loader
    import palette_pkg::*;
#(
    parameter int COUNT_W = 10,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LAYER_W-1:0]    cmd_layer,
    input  logic [COLOR_W-1:0]    cmd_color,
    input  logic [COUNT_W-1:0]    cmd_count,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PAL_DATA_W-1:0] s_data,
    output logic                  pal_write_en,
    output logic [LAYER_W-1:0]    pal_layer,
    output logic [COLOR_W-1:0]    pal_color,
    output logic [1:0]            pal_rgb,
    output logic [PAL_DATA_W-1:0] pal_write_data,
    input  logic [PAL_DATA_W-1:0] pal_read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_err
);

    loader_state_t state, next_state;
    pal_addr_t     addr;
    logic          last;
    logic          accept;
    logic          fire;
    logic          verify_done;
    logic          last_word;

    assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign fire   = (state == ST_LOAD) && s_valid && s_ready;

    palette_addr_seq #(
        .COUNT_W (COUNT_W)
    ) u_addr_seq (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .advance    (fire),
        .load_layer (cmd_layer),
        .load_color (cmd_color),
        .load_count (cmd_count),
        .addr       (addr),
        .last       (last)
    );

`ifdef PALETTE_LOADER_VERIFY_EN
    localparam int VCNT_W = $clog2(RD_LAT + 1) + 1;

    logic [VCNT_W-1:0] vcnt;
    logic              last_word_q;
    logic              verify_err_q;

    // The write strobe occupies the first VERIFY cycle; read data for that
    // address is valid RD_LAT cycles later, on the last VERIFY cycle.
    assign verify_done = (state == ST_VERIFY) && (vcnt == VCNT_W'(RD_LAT));
    assign last_word   = last_word_q;
    assign verify_err  = verify_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vcnt         <= '0;
            last_word_q  <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            if (fire) begin
                vcnt        <= '0;
                last_word_q <= last;
            end else if (state == ST_VERIFY) begin
                vcnt <= vcnt + VCNT_W'(1);
            end

            if (accept) begin
                verify_err_q <= 1'b0;
            end else if (verify_done && (pal_read_data != pal_write_data)) begin
                verify_err_q <= 1'b1;
            end
        end
    end
`else
    // VERIFY is unreachable here; if it were ever entered it exits via FINISH.
    assign verify_done = 1'b1;
    assign last_word   = 1'b1;
    assign verify_err  = 1'b0;

    logic unused_read;
    assign unused_read = (^pal_read_data) ^ (RD_LAT == 0);
`endif

    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (cmd_count == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (fire) begin
`ifdef PALETTE_LOADER_VERIFY_EN
                    next_state = ST_VERIFY;
`else
                    next_state = last ? ST_FINISH : ST_LOAD;
`endif
                end
            end
            ST_VERIFY: begin
                if (verify_done) begin
                    next_state = last_word ? ST_FINISH : ST_LOAD;
                end
            end
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Handshake/status outputs are registered from next_state so they line
    // up with the state they describe and are forced to 0 by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pal_write_en   <= 1'b0;
            pal_layer      <= '0;
            pal_color      <= '0;
            pal_rgb        <= CH_R;
            pal_write_data <= '0;
        end else begin
            state        <= next_state;
            cmd_ready    <= (next_state == ST_IDLE);
            s_ready      <= (next_state == ST_LOAD);
            busy         <= (next_state == ST_LOAD) || (next_state == ST_VERIFY);
            done         <= (next_state == ST_FINISH);
            pal_write_en <= fire;
            // Address and data only move on an accepted word, so they stay
            // put through stream bubbles and the readback window.
            if (fire) begin
                pal_layer      <= addr.layer;
                pal_color      <= addr.color;
                pal_rgb        <= addr.rgb;
                pal_write_data <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// ---------------------------------------------------------------------------
// tb_palette_loader
// Self-checking bench for palette_loader. A reference model turns each
// command into the list of expected palette writes using linear slot
// arithmetic (31 writable slots per layer, 992 in total); a monitor pops and
// compares every write the DUT issues. A small palette model answers reads
// and corrupts the G channel of color 3 so the readback flag can be seen in
// PALETTE_LOADER_VERIFY_EN builds.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_palette_loader;
    import palette_pkg::*;

    localparam int COUNT_W = 10;
    localparam int RD_LAT  = 1;
`ifdef PALETTE_LOADER_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [4:0]         cmd_layer = '0;
    logic [4:0]         cmd_color = '0;
    logic [COUNT_W-1:0] cmd_count = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [15:0]        s_data = '0;
    logic               pal_write_en;
    logic [4:0]         pal_layer;
    logic [4:0]         pal_color;
    logic [1:0]         pal_rgb;
    logic [15:0]        pal_write_data;
    logic [15:0]        pal_read_data = '0;
    logic               busy;
    logic               done;
    logic               verify_err;

    palette_loader #(
        .COUNT_W (COUNT_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_layer      (cmd_layer),
        .cmd_color      (cmd_color),
        .cmd_count      (cmd_count),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .pal_write_en   (pal_write_en),
        .pal_layer      (pal_layer),
        .pal_color      (pal_color),
        .pal_rgb        (pal_rgb),
        .pal_write_data (pal_write_data),
        .pal_read_data  (pal_read_data),
        .busy           (busy),
        .done           (done),
        .verify_err     (verify_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  layer;
        logic [4:0]  color;
        logic [1:0]  rgb;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  last_wr;
    bit   have_last = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] observed();
        return {4'h0, pal_layer, pal_color, pal_rgb, pal_write_data};
    endfunction

    // ---------------- palette model (read latency RD_LAT = 1) ----------------
    logic [15:0] pal_mem [0:4095];

    function automatic logic [15:0] stored_word(input logic [4:0] c, input logic [1:0] ch,
                                                input logic [15:0] d);
        return (c == 5'd3 && ch == 2'b01) ? (d ^ 16'h0001) : d;
    endfunction

    always @(posedge clk) begin
        if (pal_write_en) begin
            pal_mem[{pal_layer, pal_color, pal_rgb}] <= stored_word(pal_color, pal_rgb, pal_write_data);
            pal_read_data <= stored_word(pal_color, pal_rgb, pal_write_data);
        end else begin
            pal_read_data <= pal_mem[{pal_layer, pal_color, pal_rgb}];
        end
    end

    // ---------------- monitor: pops and compares every write ----------------
    always @(negedge clk) begin
        if (!rst) begin
            have_last = 1'b0;
        end else if (pal_write_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", observed(), 32'hFFFF_FFFF);
            end else begin
                last_wr   = exp_q.pop_front();
                have_last = 1'b1;
                check("write", observed(), {4'h0, last_wr});
            end
        end else if (have_last) begin
            check("hold", observed(), {4'h0, last_wr});
        end
    end

    // ---------------- reference model ----------------
    // Writable slots are numbered linearly: slot = layer*31 + (color-1).
    task automatic build_cmd(input int layer, input int color, input int count,
                             output logic [15:0] words[$], output bit exp_err);
        int base;
        int j;
        wr_t w;
        base    = layer * 31 + ((color == 0) ? 1 : color) - 1;
        exp_err = 1'b0;
        words.delete();
        for (int i = 0; i < count; i++) begin
            j = (base + i) % 992;
            for (int ch = 0; ch < 3; ch++) begin
                w.layer = 5'(j / 31);
                w.color = 5'(j % 31 + 1);
                w.rgb   = 2'(ch);
                w.data  = 16'($urandom);
                exp_q.push_back(w);
                words.push_back(w.data);
                if (VERIFY_EN && w.color == 5'd3 && ch == 1) exp_err = 1'b1;
            end
        end
    endtask

    task automatic send_word(input logic [15:0] d, input int gap);
        bit hs;
        int t;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        do begin
            hs = s_ready;
            @(posedge clk); #1;
            t++;
        end while (!hs && t < 100);
        s_valid = 1'b0;
        check("word_accepted", 32'(hs), 32'd1);
    endtask

    task automatic issue_cmd(input int layer, input int color, input int count);
        int t = 0;
        while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_layer = 5'(layer);
        cmd_color = 5'(color);
        cmd_count = COUNT_W'(count);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("verify_err_clear", 32'(verify_err), 32'd0);
    endtask

    // gap_mode: 0 = back-to-back, 1 = s_valid 1,0,0,1 pattern, 2 = random bubbles
    task automatic run_cmd(input int layer, input int color, input int count, input int gap_mode);
        logic [15:0] words[$];
        bit exp_err;
        int t;
        int gap;
        build_cmd(layer, color, count, words, exp_err);
        issue_cmd(layer, color, count);
        if (count == 0) begin
            @(negedge clk);
            check("done_zero", 32'(done), 32'd1);
            check("busy_zero", 32'(busy), 32'd0);
        end else begin
            check("busy_on", 32'(busy), 32'd1);
            check("cmd_ready_low", 32'(cmd_ready), 32'd0);
            foreach (words[k]) begin
                gap = (gap_mode == 1) ? ((k % 2 == 1) ? 2 : 0)
                    : (gap_mode == 2) ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0)
                    : 0;
                send_word(words[k], gap);
            end
            t = 0;
            @(negedge clk);
            while (!done && t < 400) begin @(negedge clk); t++; end
            check("done", 32'(done), 32'd1);
            check("busy_at_done", 32'(busy), 32'd0);
            check("verify_err", 32'(verify_err), 32'(exp_err));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("verify_err_sticky", 32'(verify_err), 32'(exp_err));
        #1;
        check("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {pal_write_en, busy, done, cmd_ready, s_ready, verify_err, 26'h0} | observed(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words[$];
        bit exp_err;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        #1 rst = 1'b1;
        @(negedge clk);
        check("cmd_ready_post_reset", 32'(cmd_ready), 32'd1);

        // Directed cases
        run_cmd(2, 5, 2, 0);      // six back-to-back writes
        run_cmd(31, 31, 2, 0);    // wraps to layer 0 color 1
        run_cmd(9, 0, 1, 0);      // color 0 promoted to 1
        run_cmd(4, 7, 0, 0);      // zero-count command
        run_cmd(3, 12, 1, 1);     // s_valid 1,0,0,1
        run_cmd(0, 2, 3, 0);      // covers color 3 G (corrupted readback)
        run_cmd(4, 10, 1, 0);     // clean command clears the flag

        // Reset in the middle of a 3-color command, after the 4th write
        build_cmd(7, 10, 3, words, exp_err);
        issue_cmd(7, 10, 3);
        for (int k = 0; k < 4; k++) send_word(words[k], 0);
        @(negedge clk);
        #1;
        exp_q.delete();
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = words[4];
        @(negedge clk);
        check_reset_outputs("reset_mid_cmd");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
        check("s_ready_after_release", 32'(s_ready), 32'd0);
        check("busy_after_release", 32'(busy), 32'd0);
        #1 s_valid = 1'b0;

        // Randomized commands
        for (int n = 0; n < 10; n++) begin
            run_cmd($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4), 2);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_loader.md
Name: palette_loader

Overview:
- Controller-side write engine for the palette memory: turns a bulk upload into per-channel palette writes.
- Accepts a load command (layer, start color, color count), then a stream of 16-bit channel words ordered R, G, B per color.
- Drives the palette's write-enable, layer, color, RGB-select and write-data inputs.
- Sits between the host register/DMA interface and the palette block.

Parameters:
- COUNT_W, 10, width of cmd_count. 992 colors max (31 writable slots x 32 layers).
- RD_LAT, 1, palette controller read latency in cycles. Used only by the verify feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  load command valid
- cmd_ready  out  1  high only in IDLE
- cmd_layer  in  5  starting layer
- cmd_color  in  5  starting color slot; 0 is treated as 1
- cmd_count  in  COUNT_W  number of colors to load (each color is 3 words)
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid && s_ready
- s_data  in  16  channel word
- pal_write_en  out  1  palette write strobe
- pal_layer  out  5  palette layer address
- pal_color  out  5  palette color address
- pal_rgb  out  2  channel select: 00 = R, 01 = G, 10 = B; 11 never driven
- pal_write_data  out  16  palette write data
- pal_read_data  in  16  palette controller read data; used only with the verify feature
- busy  out  1  high from command accept through done
- done  out  1  one-cycle pulse when a command completes
- verify_err  out  1  sticky readback mismatch flag

Behaviour:
- Reset values: every output is 0; state = IDLE; cmd_ready is 1 from the first cycle after reset.
- Reset mid-operation: the next edge with rst low returns to IDLE and drives pal_write_en = 0. The remainder of the command is discarded; it is not resumed.
- All palette-side outputs are registered.
- States: IDLE, LOAD, VERIFY (verify builds only), FINISH.
- IDLE -> LOAD on cmd_valid:
  - captures layer, color (0 -> 1) and count;
  - channel <- R;
  - busy <- 1;
  - clears verify_err.
- IDLE -> FINISH instead when cmd_count = 0: no writes are issued.
- LOAD behaviour:
  - s_ready = 1.
  - On a handshake, the next cycle shows pal_write_en = 1 with the current layer/color/channel and s_data.
  - Throughput is one word per cycle. s_valid low inserts bubbles with pal_write_en = 0.
- Channel advance: R -> G -> B -> R. After B, the color count decrements and the color increments.
- Color wrap: color 31 -> color 1 and layer + 1. Layer 31 wraps to 0. Color 0 is never addressed.
- After the final B write, LOAD -> FINISH.
- FINISH: done = 1 for one cycle, busy = 0, then IDLE.
- Words presented while not in LOAD are not accepted (s_ready = 0).
- Address and data are held stable on cycles where pal_write_en = 0.

Optional Feature:
- Macro: PALETTE_LOADER_VERIFY_EN.
- With the macro, after each write:
  - state VERIFY for RD_LAT + 1 cycles;
  - pal_write_en = 0, with pal_layer, pal_color and pal_rgb held at the written address;
  - s_ready = 0.
  - On the last VERIFY cycle, pal_read_data is compared to the written word. A mismatch sets verify_err, which stays set until the next command is accepted.
  - Then the FSM returns to LOAD, or goes to FINISH after the last word.
  - Throughput is 1 word per RD_LAT + 2 cycles.
- Without the macro: no VERIFY state, pal_read_data is ignored, and verify_err is tied to 0.

Decomposition:
- Shared package palette_pkg:
  - channel codes CH_R = 2'b00, CH_G = 2'b01, CH_B = 2'b10, CH_X = 2'b11;
  - constants LAYER_W = 5, COLOR_W = 5, PAL_DATA_W = 16, TRANSPARENT_IDX = 0;
  - the loader state enum.
- One natural sub-module, palette_addr_seq: channel/color/layer counter with the skip-0 and wrap rules. Inputs: load, advance. Outputs: address and last.

Test Plan:
- cmd layer 2, color 5, count 2; stream 0x1111..0x6666, s_valid always high -> six writes on consecutive cycles:
  - (2,5,R,0x1111), (2,5,G,0x2222), (2,5,B,0x3333);
  - (2,6,R,0x4444), (2,6,G,0x5555), (2,6,B,0x6666);
  - then done pulses once and busy drops.
- cmd layer 31, color 31, count 2 -> second color written at layer 0, color 1. Color 0 is never written.
- cmd color 0, count 1 -> writes go to color 1. cmd count 0 -> done one cycle after accept, zero writes.
- s_valid toggled 1,0,0,1 -> pal_write_en mirrors accepted words only; address is held during gaps.
- rst driven low after the 4th write of a 3-color command -> no further writes, all outputs 0, cmd_ready = 1 after release.
- PALETTE_LOADER_VERIFY_EN, RD_LAT = 1, palette model corrupting G of color 3 -> verify_err set and still high after done. The next accepted command clears it.
